// File: rtl/adc_capture_writer.sv
// adc_capture_writer: block-averages the ADC sample stream and fills the adc_offs or adc_meas RAM.
// Latency: a word is written one cycle after the last sample of its group; done_o one cycle after the last write.
// Backpressure: none; one sample is accepted every cycle while capturing, and samples outside a capture are dropped.
// Ports: clk_i/rst_n_i (sync active-low); start_i/abort_i/target_i/avg_log2_i/count_i control;
//        adc_valid_i/adc_data_i sample stream; adc_{offs,meas}_{adr,data_we,data_dat}_o RAM B-port writes;
//        busy_o/done_o sequencer status.
module adc_capture_writer #(
  parameter int g_adc_width    = 24,
  parameter int g_addr_width   = 12,
  parameter int g_max_avg_log2 = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    target_i,
  input  logic [3:0]              avg_log2_i,
  input  logic [g_addr_width:0]   count_i,
  input  logic                    adc_valid_i,
  input  logic [g_adc_width-1:0]  adc_data_i,
  output logic [g_addr_width-1:0] adc_offs_adr_o,
  output logic                    adc_offs_data_we_o,
  output logic [31:0]             adc_offs_data_dat_o,
  output logic [g_addr_width-1:0] adc_meas_adr_o,
  output logic                    adc_meas_data_we_o,
  output logic [31:0]             adc_meas_data_dat_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int ACC_W = g_adc_width + g_max_avg_log2;
  localparam int CNT_W = g_addr_width + 1;
  localparam int SMP_W = g_max_avg_log2 + 1;

  // S_LAST is the cycle in which the final word's write strobe is on the port.
  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_LAST, S_DONE} state_t;

  state_t state_q, state_d;

  logic                    target_q, target_d;
  logic [3:0]              avg_q, avg_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        word_q, word_d;
  logic [SMP_W-1:0]        samp_q, samp_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic                    offs_we_q, offs_we_d;
  logic [g_addr_width-1:0] offs_adr_q, offs_adr_d;
  logic [31:0]             offs_dat_q, offs_dat_d;
  logic                    meas_we_q, meas_we_d;
  logic [g_addr_width-1:0] meas_adr_q, meas_adr_d;
  logic [31:0]             meas_dat_q, meas_dat_d;

  logic                    accept;
  logic                    group_end;
  logic                    last_word;
  logic [SMP_W-1:0]        grp_last_idx;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] avg_val;
  logic [31:0]             dat_word;

  // Abort takes priority: a sample arriving together with abort is never counted.
  assign accept       = (state_q == S_CAPT) && adc_valid_i && !abort_i;
  assign grp_last_idx = (SMP_W'(1) << avg_q) - SMP_W'(1);
  assign group_end    = (samp_q == grp_last_idx);
  assign last_word    = (word_q == count_q - CNT_W'(1));

  assign sample_ext = {{g_max_avg_log2{adc_data_i[g_adc_width-1]}}, adc_data_i};
  assign sum        = acc_q + sample_ext;
  assign avg_val    = sum >>> avg_q;

  if (ACC_W >= 32) begin : g_dat_trunc
    assign dat_word = avg_val[31:0];
  end else begin : g_dat_sext
    assign dat_word = {{(32-ACC_W){avg_val[ACC_W-1]}}, avg_val};
  end

  // State register and all datapath flops.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      target_q   <= 1'b0;
      avg_q      <= '0;
      count_q    <= '0;
      word_q     <= '0;
      samp_q     <= '0;
      acc_q      <= '0;
      offs_we_q  <= 1'b0;
      offs_adr_q <= '0;
      offs_dat_q <= '0;
      meas_we_q  <= 1'b0;
      meas_adr_q <= '0;
      meas_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      avg_q      <= avg_d;
      count_q    <= count_d;
      word_q     <= word_d;
      samp_q     <= samp_d;
      acc_q      <= acc_d;
      offs_we_q  <= offs_we_d;
      offs_adr_q <= offs_adr_d;
      offs_dat_q <= offs_dat_d;
      meas_we_q  <= meas_we_d;
      meas_adr_q <= meas_adr_d;
      meas_dat_q <= meas_dat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i && !abort_i) state_d = S_CAPT;
      S_CAPT: begin
        if (abort_i)                             state_d = S_IDLE;
        else if (accept && group_end && last_word) state_d = S_LAST;
      end
      S_LAST: state_d = abort_i ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture datapath: parameter latch on start, accumulation, word write.
  always_comb begin
    target_d   = target_q;
    avg_d      = avg_q;
    count_d    = count_q;
    word_d     = word_q;
    samp_d     = samp_q;
    acc_d      = acc_q;
    offs_we_d  = 1'b0;
    offs_adr_d = offs_adr_q;
    offs_dat_d = offs_dat_q;
    meas_we_d  = 1'b0;
    meas_adr_d = meas_adr_q;
    meas_dat_d = meas_dat_q;

    if (state_q == S_IDLE && start_i && !abort_i) begin
      target_d = target_i;
      avg_d    = (int'(avg_log2_i) > g_max_avg_log2) ? 4'(g_max_avg_log2) : avg_log2_i;
      // A zero count stands for a full RAM, which needs the extra counter bit.
      count_d  = (count_i == '0) ? {1'b1, {g_addr_width{1'b0}}} : count_i;
      word_d   = '0;
      samp_d   = '0;
      acc_d    = '0;
    end

    if (accept) begin
      if (group_end) begin
        if (target_q) begin
          meas_we_d  = 1'b1;
          meas_adr_d = word_q[g_addr_width-1:0];
          meas_dat_d = dat_word;
        end else begin
          offs_we_d  = 1'b1;
          offs_adr_d = word_q[g_addr_width-1:0];
          offs_dat_d = dat_word;
        end
        word_d = word_q + CNT_W'(1);
        samp_d = '0;
        acc_d  = '0;
      end else begin
        samp_d = samp_q + SMP_W'(1);
        acc_d  = sum;
      end
    end
  end

  // Output decode.
  always_comb begin
    busy_o = (state_q == S_CAPT) || (state_q == S_LAST);
    done_o = (state_q == S_DONE);
  end

  assign adc_offs_adr_o      = offs_adr_q;
  assign adc_offs_data_we_o  = offs_we_q;
  assign adc_offs_data_dat_o = offs_dat_q;
  assign adc_meas_adr_o      = meas_adr_q;
  assign adc_meas_data_we_o  = meas_we_q;
  assign adc_meas_data_dat_o = meas_dat_q;

endmodule
